// File: rtl/alu_rr_scheduler.sv
// alu_rr_scheduler: round-robin arbiter that shares one external ALU among NUM_REQ requesters
module alu_rr_scheduler #(
  parameter int NUM_REQ = 2,
  parameter int MULDIV_CYCLES = 4,
  parameter int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [3*NUM_REQ-1:0]    req_opcode,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic [31:0]             alu_a,
  output logic [31:0]             alu_b,
  output logic [2:0]              alu_opcode,
  input  logic [63:0]             alu_res,
  input  logic                    alu_ov,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [63:0]             rsp_res,
  output logic                    rsp_ov,
  output logic                    busy,
  output logic [31:0]             ops_done
);
  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] last_q, last_d, id_q, id_d, win;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, ops_q, ops_d, a_sel, b_sel;
  logic [2:0] op_q, op_d, op_sel;
  logic [63:0] res_q, res_d;
  logic ov_q, ov_d, vld_q, vld_d, found;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = 0; k < NUM_REQ; k++)
      for (int i = 0; i < NUM_REQ; i++)
        if (!found && req_valid[i] && i == (int'(last_q) + 1 + k) % NUM_REQ) begin
          found = 1'b1;
          win = ID_W'(i);
        end
    op_sel = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (win == ID_W'(i)) begin
        op_sel = req_opcode[3*i +: 3];
        a_sel = req_a[32*i +: 32];
        b_sel = req_b[32*i +: 32];
      end
    for (int i = 0; i < NUM_REQ; i++)
      req_ready[i] = (state_q == IDLE) && found && (win == ID_W'(i));
  end
  always_comb begin
    state_d = state_q;
    last_d = last_q;
    id_d = id_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    op_d = op_q;
    res_d = res_q;
    ov_d = ov_q;
    vld_d = vld_q;
    ops_d = ops_q;
    if (state_q == IDLE && found) begin
      a_d = a_sel;
      b_d = b_sel;
      op_d = op_sel;
      id_d = win;
      last_d = win;
      cnt_d = (op_sel[2:1] == 2'b01) ? CNT_W'(MULDIV_CYCLES - 1) : '0;
      state_d = EXEC;
    end else if (state_q == EXEC && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end else if (state_q == EXEC) begin
      res_d = alu_res;
      ov_d = alu_ov;
      vld_d = 1'b1;
      state_d = RESP;
    end else if (state_q == RESP && rsp_ready) begin
      vld_d = 1'b0;
      ops_d = ops_q + 32'd1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q <= ID_W'(NUM_REQ - 1);
      id_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res_q <= '0;
      ov_q <= 1'b0;
      vld_q <= 1'b0;
      ops_q <= '0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      op_q <= op_d;
      res_q <= res_d;
      ov_q <= ov_d;
      vld_q <= vld_d;
      ops_q <= ops_d;
    end
  end
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_opcode = op_q;
  assign rsp_valid = vld_q;
  assign rsp_id = id_q;
  assign rsp_res = res_q;
  assign rsp_ov = ov_q;
  assign busy = state_q != IDLE;
  assign ops_done = ops_q;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// tb_alu_rr_scheduler: randomized self-checking bench with an ALU stub and reference model
module tb_alu_rr_scheduler;
  localparam int NREQ = 2;
  localparam int MDC = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req_valid, req_ready;
  logic [3*NREQ-1:0] req_opcode;
  logic [32*NREQ-1:0] req_a, req_b;
  logic [31:0] alu_a, alu_b, ops_done;
  logic [2:0] alu_opcode;
  logic [63:0] alu_res, rsp_res;
  logic alu_ov, rsp_valid, rsp_ready, rsp_ov, busy;
  logic [0:0] rsp_id;
  logic vld [NREQ];
  logic [2:0] op_arr [NREQ];
  logic [31:0] a_arr [NREQ], b_arr [NREQ];
  int checks = 0, errors = 0, exp_ops = 0, last_g = NREQ - 1;
  always #5 clk = ~clk;
  always_comb
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = vld[i];
      req_opcode[3*i +: 3] = op_arr[i];
      req_a[32*i +: 32] = a_arr[i];
      req_b[32*i +: 32] = b_arr[i];
    end
  function automatic logic [64:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    case (op)
      3'd0: begin s = a + b; return {(a[31] == b[31]) && (s[31] != a[31]), 32'd0, s}; end
      3'd1: begin s = a - b; return {(a[31] != b[31]) && (s[31] != a[31]), 32'd0, s}; end
      3'd2: return {1'b0, 64'(a) * 64'(b)};
      3'd3: return (b == 0) ? 65'd0 : {1'b0, a % b, a / b};
      3'd4: return {33'd0, a << b[4:0]};
      3'd5: return {33'd0, a >> b[4:0]};
      3'd6: return {33'd0, a & b};
      default: return {33'd0, a | b};
    endcase
  endfunction
  assign {alu_ov, alu_res} = alu_ref(alu_opcode, alu_a, alu_b);
  alu_rr_scheduler #(.NUM_REQ(NREQ), .MULDIV_CYCLES(MDC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_res(alu_res), .alu_ov(alu_ov), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_res(rsp_res), .rsp_ov(rsp_ov), .busy(busy), .ops_done(ops_done)
  );
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    int lat;
    logic [64:0] e;
    lat = (op == 3'd2 || op == 3'd3) ? MDC : 1;
    e = alu_ref(op, a, b);
    op_arr[r] = op; a_arr[r] = a; b_arr[r] = b;
    rsp_ready = 1'b1;
    vld[r] = 1'b1;
    #1;
    n = 0;
    while (req_ready !== NREQ'(1 << r) && n < 20) begin step; n++; end
    checks++;
    if (n >= 20) begin errors++; $display("FAIL grant_timeout req=%0d ready=%b expected %b", r, req_ready, NREQ'(1 << r)); vld[r] = 1'b0; return; end
    step;
    vld[r] = 1'b0;
    last_g = r;
    checks++;
    if (alu_a !== a || alu_b !== b || alu_opcode !== op || busy !== 1'b1)
      begin errors++; $display("FAIL latch a=%h b=%h op=%0d busy=%b expected a=%h b=%h op=%0d busy=1", alu_a, alu_b, alu_opcode, busy, a, b, op); end
    n = 0;
    while (!rsp_valid && n < lat + 5) begin
      checks++;
      if (alu_a !== a || alu_b !== b) begin errors++; $display("FAIL hold a=%h b=%h expected a=%h b=%h", alu_a, alu_b, a, b); end
      step;
      n++;
    end
    checks++;
    if (n != lat) begin errors++; $display("FAIL latency op=%0d got %0d expected %0d", op, n, lat); end
    checks++;
    if (rsp_res !== e[63:0] || rsp_ov !== e[64] || rsp_id !== 1'(r))
      begin errors++; $display("FAIL rsp op=%0d res=%h ov=%b id=%0d expected res=%h ov=%b id=%0d", op, rsp_res, rsp_ov, rsp_id, e[63:0], e[64], r); end
    step;
    exp_ops++;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 32'(exp_ops))
      begin errors++; $display("FAIL done valid=%b busy=%b ops=%0d expected 0 0 %0d", rsp_valid, busy, ops_done, exp_ops); end
  endtask
  task automatic test_reset;
    for (int i = 0; i < NREQ; i++) begin vld[i] = 1'b0; op_arr[i] = '0; a_arr[i] = '0; b_arr[i] = '0; end
    rsp_ready = 1'b1;
    rst = 1'b1;
    step; step;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 32'd0 || alu_a !== 32'd0 || alu_b !== 32'd0 || alu_opcode !== 3'd0 || rsp_res !== 64'd0 || req_ready !== '0)
      begin errors++; $display("FAIL reset valid=%b busy=%b ops=%0d a=%h b=%h res=%h ready=%b expected all 0", rsp_valid, busy, ops_done, alu_a, alu_b, rsp_res, req_ready); end
    #2 rst = 1'b0;
    exp_ops = 0;
    last_g = NREQ - 1;
    step;
  endtask
  task automatic test_single_add;
    run_op(0, 3'd0, 32'd5, 32'd7);
    checks++;
    if (rsp_res !== 64'd12 || ops_done !== 32'd1) begin errors++; $display("FAIL add res=%0d ops=%0d expected 12 1", rsp_res, ops_done); end
  endtask
  task automatic test_mul;
    run_op(1, 3'd2, 32'hFFFF_FFFF, 32'd2);
    checks++;
    if (rsp_res !== 64'h1_FFFF_FFFE) begin errors++; $display("FAIL mul res=%h expected 1fffffffe", rsp_res); end
  endtask
  task automatic test_round_robin;
    int got = 0;
    int q[$];
    int ew;
    rsp_ready = 1'b1;
    op_arr[0] = 3'd0; a_arr[0] = 32'd1; b_arr[0] = 32'd1;
    op_arr[1] = 3'd0; a_arr[1] = 32'd2; b_arr[1] = 32'd2;
    vld[0] = 1'b1; vld[1] = 1'b1;
    #1;
    for (int n = 0; n < 80 && got < 4; n++) begin
      checks++;
      if ($countones(req_ready) > 1) begin errors++; $display("FAIL rr_onehot ready=%b expected at most one bit", req_ready); end
      if (req_ready != '0) begin
        ew = (last_g + 1) % NREQ;
        checks++;
        if (req_ready !== NREQ'(1 << ew)) begin errors++; $display("FAIL rr_grant ready=%b expected %b", req_ready, NREQ'(1 << ew)); end
        q.push_back(ew);
        last_g = ew;
      end
      if (rsp_valid) begin
        ew = (q.size() > 0) ? q.pop_front() : -1;
        checks++;
        if (rsp_id !== 1'(ew) || rsp_res !== ((ew == 1) ? 64'd4 : 64'd2))
          begin errors++; $display("FAIL rr_rsp id=%0d res=%0d expected id=%0d", rsp_id, rsp_res, ew); end
        got++;
        exp_ops++;
      end
      step;
    end
    vld[0] = 1'b0; vld[1] = 1'b0;
    checks++;
    if (got != 4 || ops_done !== 32'(exp_ops)) begin errors++; $display("FAIL rr_count responses=%0d ops=%0d expected 4 %0d", got, ops_done, exp_ops); end
  endtask
  task automatic test_back_pressure;
    logic [31:0] a0, a1;
    logic [64:0] e0, e1;
    int n;
    a0 = $urandom; a1 = $urandom;
    op_arr[0] = 3'd0; a_arr[0] = a0; b_arr[0] = 32'd3;
    e0 = alu_ref(3'd0, a0, 32'd3);
    e1 = alu_ref(3'd6, a1, 32'h0F0F_0F0F);
    rsp_ready = 1'b0;
    vld[0] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[0] && n < 20) begin step; n++; end
    step;
    last_g = 0;
    op_arr[1] = 3'd6; a_arr[1] = a1; b_arr[1] = 32'h0F0F_0F0F;
    vld[1] = 1'b1;
    n = 0;
    while (!rsp_valid && n < 20) begin step; n++; end
    checks++;
    if (!rsp_valid || rsp_res !== e0[63:0] || rsp_id !== 1'b0) begin errors++; $display("FAIL bp_first valid=%b res=%h id=%0d expected 1 %h 0", rsp_valid, rsp_res, rsp_id, e0[63:0]); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_res !== e0[63:0] || rsp_id !== 1'b0 || rsp_ov !== e0[64] || req_ready !== '0 || alu_a !== a0)
        begin errors++; $display("FAIL bp_hold valid=%b res=%h id=%0d ready=%b a=%h expected 1 %h 0 00 %h", rsp_valid, rsp_res, rsp_id, req_ready, alu_a, e0[63:0], a0); end
      step;
    end
    rsp_ready = 1'b1;
    step;
    exp_ops++;
    checks++;
    if (rsp_valid !== 1'b0 || ops_done !== 32'(exp_ops) || req_ready !== 2'b10)
      begin errors++; $display("FAIL bp_release valid=%b ops=%0d ready=%b expected 0 %0d 10", rsp_valid, ops_done, req_ready, exp_ops); end
    step;
    last_g = 1;
    vld[0] = 1'b0; vld[1] = 1'b0;
    checks++;
    if (busy !== 1'b1 || alu_a !== a1) begin errors++; $display("FAIL bp_next busy=%b a=%h expected 1 %h", busy, alu_a, a1); end
    n = 0;
    while (!rsp_valid && n < 20) begin step; n++; end
    checks++;
    if (rsp_id !== 1'b1 || rsp_res !== e1[63:0]) begin errors++; $display("FAIL bp_second id=%0d res=%h expected 1 %h", rsp_id, rsp_res, e1[63:0]); end
    step;
    exp_ops++;
    checks++;
    if (ops_done !== 32'(exp_ops)) begin errors++; $display("FAIL bp_ops ops=%0d expected %0d", ops_done, exp_ops); end
  endtask
  task automatic test_divzero_ov;
    run_op(0, 3'd3, 32'd9, 32'd0);
    checks++;
    if (rsp_res !== 64'd0) begin errors++; $display("FAIL div0 res=%h expected 0", rsp_res); end
    run_op(1, 3'd1, 32'h8000_0000, 32'd1);
    checks++;
    if (rsp_res !== 64'h7FFF_FFFF || rsp_ov !== 1'b1) begin errors++; $display("FAIL subov res=%h ov=%b expected 7fffffff 1", rsp_res, rsp_ov); end
  endtask
  task automatic test_random;
    for (int k = 0; k < 16; k++)
      run_op(int'($urandom_range(0, NREQ - 1)), 3'($urandom_range(0, 7)), $urandom,
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom);
  endtask
  task automatic test_async_reset;
    int n;
    op_arr[1] = 3'd2; a_arr[1] = 32'd123; b_arr[1] = 32'd456;
    vld[1] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[1] && n < 20) begin step; n++; end
    step;
    vld[1] = 1'b0;
    step;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || ops_done !== 32'd0 || alu_a !== 32'd0)
      begin errors++; $display("FAIL async_rst valid=%b busy=%b ops=%0d a=%h expected 0 0 0 0", rsp_valid, busy, ops_done, alu_a); end
    #2 rst = 1'b0;
    exp_ops = 0;
    last_g = NREQ - 1;
    vld[0] = 1'b1; vld[1] = 1'b1;
    #1;
    checks++;
    if (req_ready !== 2'b01) begin errors++; $display("FAIL rst_prio ready=%b expected 01", req_ready); end
    vld[0] = 1'b0; vld[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step;
      checks++;
      if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL stale valid=%b busy=%b expected 0 0", rsp_valid, busy); end
    end
  endtask
  initial begin
    test_reset;
    test_single_add;
    test_mul;
    test_round_robin;
    test_back_pressure;
    test_divzero_ov;
    test_random;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_rr_scheduler.md
Name: alu_rr_scheduler

Overview:
- Shares one combinational 32-bit ALU (ops: add, sub, mul, div/rem, shifts, and, or) among NUM_REQ requesters.
- Round-robin arbitration; valid/ready handshake per requester.
- Registers operands and holds them stable for the ALU's multicycle paths. Mul/div get MULDIV_CYCLES cycles; all other ops get 1 cycle.
- Returns each result on one shared response channel, tagged with the requester id. Sits between the issue logic and the ALU instance.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- MULDIV_CYCLES, 4, cycles the ALU inputs are held for opcode 3'b010 (mul) and 3'b011 (div/rem); must be >= 1.
- ID_W, $clog2(NUM_REQ) (min 1), width of rsp_id.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_opcode  in  3*NUM_REQ  opcode of requester i at [3i+2:3i].
- req_a  in  32*NUM_REQ  operand a of requester i at [32i+31:32i].
- req_b  in  32*NUM_REQ  operand b of requester i at [32i+31:32i].
- alu_a  out  32  to ALU a.
- alu_b  out  32  to ALU b.
- alu_opcode  out  3  to ALU opcode.
- alu_res  in  64  from ALU res.
- alu_ov  in  1  from ALU ov.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_res  out  64  captured result.
- rsp_ov  out  1  captured overflow flag.
- busy  out  1  high in EXEC or RESP.
- ops_done  out  32  count of completed response handshakes; wraps 2^32-1 -> 0.

Behaviour:
- States: IDLE, EXEC, RESP.
- Reset (async, immediate):
  - state=IDLE; all outputs 0.
  - rr pointer set so requester 0 has top priority.
  - Exec counter 0; ops_done 0.
  - Reset mid-EXEC or mid-RESP aborts the operation; no response is ever issued for it.
- IDLE, arbitration:
  - Winner = first i with req_valid[i], searching from (last_grant+1) mod NUM_REQ upward with wrap.
  - req_ready[winner]=1 combinationally, only in IDLE; all other req_ready bits are 0.
  - Handshake = req_valid[i] && req_ready[i].
- IDLE, on handshake (edge E0):
  - Latch opcode/a/b into alu_* registers and latch id.
  - last_grant <= winner.
  - cnt <= (opcode is 010 or 011) ? MULDIV_CYCLES-1 : 0.
  - state <= EXEC.
- EXEC:
  - alu_a, alu_b and alu_opcode are held constant.
  - cnt>0: decrement.
  - cnt==0: capture alu_res/alu_ov into rsp_res/rsp_ov, rsp_valid <= 1, state <= RESP.
  - Timing: a simple op has rsp_valid visible after E1; mul/div after E_MULDIV_CYCLES.
- RESP:
  - rsp_* hold stable while rsp_valid && !rsp_ready.
  - On handshake: rsp_valid <= 0, ops_done += 1, state <= IDLE.
  - No new request is accepted in the same cycle. Minimum spacing between accepts is (exec cycles + 2).
- alu_* keep their last values in IDLE; they change only on an accept.
- Requesters must hold req_* stable while valid && !ready. A requester dropping valid before grant simply loses its turn; no error is raised.
- Arithmetic is performed entirely by the ALU. The scheduler passes alu_res and alu_ov through unmodified, including the ALU's 0 result for divide-by-zero.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,NUM_REQ-1,0,...; no requester waits more than NUM_REQ-1 grants.

Test Plan:
- Reset then single add: req0 op=000, a=5, b=7 accepted at E0 -> rsp_valid after E1; rsp_res=12, rsp_id=0, ov=0, busy high from E0 until the rsp handshake, ops_done=1.
- Mul latency: MULDIV_CYCLES=4, req1 op=010, a=0xFFFF_FFFF, b=2 -> rsp_valid first seen after E4 (not earlier); rsp_res=0x1_FFFF_FFFE; alu_a/alu_b constant throughout E0..E4.
- Round-robin: both requesters valid continuously with adds (1+1, 2+2) -> grant order 0,1,0,1; rsp_id alternates; req_ready never high for both at once.
- Back-pressure: rsp_ready=0 for 10 cycles after rsp_valid -> rsp_res/rsp_id/rsp_ov stable, req_ready all 0, no new accept; rsp_ready=1 -> handshake, next request accepted the following cycle.
- Div-by-zero and sub overflow: op=011, a=9, b=0 -> rsp_res=0. op=001, a=0x8000_0000, b=1 -> rsp_res=0x7FFF_FFFF, rsp_ov=1.
- Async reset mid-EXEC of a mul: rst pulsed between clock edges -> rsp_valid=0, busy=0, req_ready reflects requester 0 priority immediately after release, and no stale response appears.
